instr_encoder_loader: RTL and testbench

//  Encodes abstract instruction requests (kind, regs, immediate) into 32-bit words in the CPU's ARM-subset format.

---
 rtl/instr_encoder_loader_pkg.sv | 46 ++++
 rtl/instr_encoder_loader_if.sv | 40 ++++
 rtl/instr_encoder_loader_field_encoder.sv | 80 ++++++++
 rtl/instr_encoder_loader.sv | 102 ++++++++++
 tb/tb_instr_encoder_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// ISA constants and types shared by the instruction encoder/loader and the decode-side control unit.
// Covers instruction kinds, data-processing commands, op classes and bit positions of each field.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    K_ADD = 4'd0,
    K_SUB = 4'd1,
    K_AND = 4'd2,
    K_ORR = 4'd3,
    K_CMP = 4'd4,
    K_MOV = 4'd5,
    K_LDR = 4'd6,
    K_STR = 4'd7,
    K_B   = 4'd8
  } kind_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam int POS_COND = 28;
  localparam int POS_OP   = 26;
  localparam int POS_I    = 25;
  localparam int POS_CMD  = 21;
  localparam int POS_S    = 20;
  localparam int POS_RN   = 16;
  localparam int POS_RD   = 12;

  // Bits [25:20] of a load/store word before the L bit is merged in.
  localparam logic [5:0] MEM_FUNCT = 6'b011000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } ld_state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Host request channel, instruction-memory write port and status of the encoder/loader.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; a memory write completes on an edge where imem_we && imem_ready.
interface instr_encoder_loader_if #(parameter int AW = 8);
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic          req_imm;
  logic [3:0]    req_rd;
  logic [3:0]    req_rn;
  logic [3:0]    req_rm;
  logic [23:0]   req_imm24;
  logic          req_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  modport slave (
    input  base_load, base_addr, req_valid, req_kind, req_imm, req_rd, req_rn, req_rm,
           req_imm24, req_last, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata, wr_addr, count, done, err
  );

  modport master (
    output base_load, base_addr, req_valid, req_kind, req_imm, req_rd, req_rn, req_rm,
           req_imm24, req_last,
    input  req_ready, wr_addr, count, done, err
  );

  modport mem (
    input  imem_we, imem_addr, imem_wdata,
    output imem_ready
  );
endinterface

// File: rtl/instr_encoder_loader_field_encoder.sv
// Combinational encoder: instruction kind plus operand fields -> 32-bit ARM-subset word.
// Unknown kinds produce a zero word and raise illegal_o.
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
#(
  parameter logic [3:0] COND = COND_AL
) (
  input  logic [3:0]  kind_i,
  input  logic        imm_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rm_i,
  input  logic [23:0] imm24_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [3:0]  cmd;
  logic        s_bit;
  logic        is_dp;
  logic [3:0]  rd_f;
  logic [3:0]  rn_f;
  logic [11:0] op2;

  always_comb begin
    cmd   = CMD_ADD;
    s_bit = 1'b0;
    is_dp = 1'b1;
    rd_f  = rd_i;
    rn_f  = rn_i;
    op2   = imm_i ? {4'h0, imm24_i[7:0]} : {8'h0, rm_i};
    case (kind_i)
      K_ADD:   cmd = CMD_ADD;
      K_SUB:   cmd = CMD_SUB;
      K_AND:   cmd = CMD_AND;
      K_ORR:   cmd = CMD_ORR;
      // Compare only sets flags, so Rd is meaningless; move has no first operand.
      K_CMP: begin
        cmd   = CMD_CMP;
        s_bit = 1'b1;
        rd_f  = 4'h0;
      end
      K_MOV: begin
        cmd  = CMD_MOV;
        rn_f = 4'h0;
      end
      default: is_dp = 1'b0;
    endcase
  end

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    if (is_dp) begin
      word_o[POS_COND +: 4] = COND;
      word_o[POS_OP +: 2]   = OP_DP;
      word_o[POS_I]         = imm_i;
      word_o[POS_CMD +: 4]  = cmd;
      word_o[POS_S]         = s_bit;
      word_o[POS_RN +: 4]   = rn_f;
      word_o[POS_RD +: 4]   = rd_f;
      word_o[11:0]          = op2;
    end else if (kind_i == K_LDR || kind_i == K_STR) begin
      word_o[POS_COND +: 4] = COND;
      word_o[POS_OP +: 2]   = OP_MEM;
      word_o[25:20]         = MEM_FUNCT | {5'b0, kind_i == K_LDR};
      word_o[POS_RN +: 4]   = rn_i;
      word_o[POS_RD +: 4]   = rd_i;
      word_o[11:0]          = imm24_i[11:0];
    end else if (kind_i == K_B) begin
      word_o[POS_COND +: 4] = COND;
      word_o[POS_OP +: 2]   = OP_BR;
      word_o[25:24]         = 2'b10;
      word_o[23:0]          = imm24_i;
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts abstract instruction requests, encodes them and writes them sequentially into instruction memory.
// Two-state FSM: IDLE accepts a request, WRITE holds the registered word until memory takes it.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int         AW   = 8,
  parameter logic [3:0] COND = COND_AL
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_encoder_loader_if.slave    bus,
  output ld_state_e                dbg_state_o
);

  ld_state_e     state_q;
  logic          req_ready_q;
  logic          imem_we_q;
  logic [AW-1:0] imem_addr_q;
  logic [31:0]   imem_wdata_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW:0]   count_q;
  logic          last_q;
  logic          done_q;
  logic          err_q;

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          accept;
  logic [AW-1:0] start_addr;

  instr_field_encoder #(.COND(COND)) u_field_encoder (
    .kind_i   (bus.req_kind),
    .imm_i    (bus.req_imm),
    .rd_i     (bus.req_rd),
    .rn_i     (bus.req_rn),
    .rm_i     (bus.req_rm),
    .imm24_i  (bus.req_imm24),
    .word_o   (enc_word),
    .illegal_o(enc_illegal)
  );

  assign accept     = bus.req_valid & req_ready_q;
  // A base load in the same cycle as a request redirects that request too.
  assign start_addr = bus.base_load ? bus.base_addr : wr_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      wr_addr_q    <= '0;
      count_q      <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.base_load) wr_addr_q <= bus.base_addr;
          if (accept) begin
            if (enc_illegal) begin
              err_q <= 1'b1;
            end else begin
              state_q      <= ST_WRITE;
              req_ready_q  <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_addr_q  <= start_addr;
              imem_wdata_q <= enc_word;
              last_q       <= bus.req_last;
            end
          end
        end
        ST_WRITE: begin
          if (bus.imem_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            imem_we_q   <= 1'b0;
            wr_addr_q   <= wr_addr_q + 1'b1;
            if (count_q != '1) count_q <= count_q + 1'b1;
            done_q      <= last_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed ISA vectors, stalls, wrap, illegal kinds, reset mid-write, random traffic.
// A cycle-level reference model (pending-write queue plus counters) is compared with the DUT on every falling edge.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic      clk;
  logic      reset;
  ld_state_e dbg_state;

  instr_encoder_loader_if #(.AW(8)) bus ();

  instr_encoder_loader #(.AW(8), .COND(4'hE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference encoding ----------------
  function automatic logic [31:0] enc(input int k, input int imm, input int rd, input int rn,
                                      input int rm, input int i24);
    logic [31:0] w;
    int cmd, op2, rnv, rdv;
    w = 32'hE000_0000;
    if (k <= 5) begin
      case (k)
        0: cmd = 4;
        1: cmd = 2;
        2: cmd = 0;
        3: cmd = 12;
        4: cmd = 10;
        default: cmd = 13;
      endcase
      op2 = (imm != 0) ? (i24 % 256) : rm;
      rnv = (k == 5) ? 0 : rn;
      rdv = (k == 4) ? 0 : rd;
      w = w + imm * 33554432 + cmd * 2097152 + ((k == 4) ? 1048576 : 0)
            + rnv * 65536 + rdv * 4096 + op2;
    end else if (k <= 7) begin
      w = w + 67108864 + (24 + ((k == 6) ? 1 : 0)) * 1048576 + rn * 65536 + rd * 4096 + (i24 % 4096);
    end else begin
      w = w + 10 * 16777216 + i24;
    end
    return w;
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [40:0] exp_q[$];   // {last, addr[7:0], data[31:0]} of accepted, not yet written words
  logic        m_ready;
  logic [7:0]  m_wr_addr;
  int          m_count;
  logic        m_err;
  logic        m_done;

  always @(negedge clk) begin
    logic [40:0] e;
    logic [7:0]  a;
    logic        done_n;
    if (reset) begin
      exp_q.delete();
      m_ready   = 1'b0;
      m_wr_addr = 8'h00;
      m_count   = 0;
      m_err     = 1'b0;
      m_done    = 1'b0;
      chk("rst_imem_addr", bus.imem_addr, 8'h00);
      chk("rst_imem_wdata", bus.imem_wdata, 32'h0);
    end
    chk("req_ready", bus.req_ready, m_ready && exp_q.size() == 0);
    chk("imem_we", bus.imem_we, exp_q.size() != 0);
    chk("state", dbg_state, (exp_q.size() != 0) ? ST_WRITE : ST_IDLE);
    if (exp_q.size() != 0) begin
      chk("imem_addr", bus.imem_addr, exp_q[0][39:32]);
      chk("imem_wdata", bus.imem_wdata, exp_q[0][31:0]);
    end
    chk("wr_addr", bus.wr_addr, m_wr_addr);
    chk("count", bus.count, m_count);
    chk("done", bus.done, m_done);
    chk("err", bus.err, m_err);
    if (!reset) begin
      done_n = 1'b0;
      if (exp_q.size() != 0) begin
        if (bus.imem_ready === 1'b1) begin
          e = exp_q.pop_front();
          if (m_count < 511) m_count++;
          m_wr_addr = m_wr_addr + 8'd1;
          done_n = e[40];
        end
      end else if (m_ready) begin
        if (bus.req_valid) begin
          a = bus.base_load ? bus.base_addr : m_wr_addr;
          if (bus.base_load) m_wr_addr = bus.base_addr;
          if (bus.req_kind > 4'd8) m_err = 1'b1;
          else exp_q.push_back({bus.req_last, a, enc(int'(bus.req_kind), int'(bus.req_imm),
                                int'(bus.req_rd), int'(bus.req_rn), int'(bus.req_rm), int'(bus.req_imm24))});
        end else if (bus.base_load) begin
          m_wr_addr = bus.base_addr;
        end
      end
      m_done  = done_n;
      m_ready = 1'b1;
    end
  end

  // ---------------- memory responder ----------------
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: ready on 4th cycle of each write
  int we_cycles = 0;
  initial begin
    bus.imem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_we) we_cycles++;
      else we_cycles = 0;
      case (rdy_mode)
        0: bus.imem_ready = 1'b1;
        1: bus.imem_ready = 1'($urandom_range(0, 1));
        default: bus.imem_ready = (we_cycles >= 4);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] k, input logic imm, input logic [3:0] rd, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [23:0] i24, input logic last,
                      input logic bl, input logic [7:0] ba);
    bit ok;
    @(posedge clk);
    #1;
    bus.req_kind  = k;
    bus.req_imm   = imm;
    bus.req_rd    = rd;
    bus.req_rn    = rn;
    bus.req_rm    = rm;
    bus.req_imm24 = i24;
    bus.req_last  = last;
    bus.base_load = bl;
    bus.base_addr = ba;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.base_load = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.imem_we === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.base_load = 1'b0;
    bus.base_addr = 8'h00;
    bus.req_kind  = 4'h0;
    bus.req_imm   = 1'b0;
    bus.req_rd    = 4'h0;
    bus.req_rn    = 4'h0;
    bus.req_rm    = 4'h0;
    bus.req_imm24 = 24'h0;
    bus.req_last  = 1'b0;

    chk("pin_add", enc(0, 1, 1, 2, 0, 5), 32'hE2821005);
    chk("pin_cmp", enc(4, 0, 3, 3, 4, 0), 32'hE1530004);
    chk("pin_mov", enc(5, 1, 7, 9, 0, 255), 32'hE3A070FF);
    chk("pin_ldr", enc(6, 0, 5, 6, 0, 8), 32'hE5965008);
    chk("pin_str", enc(7, 0, 5, 6, 0, 8), 32'hE5865008);
    chk("pin_b", enc(8, 0, 0, 0, 0, 24'hFFFFFE), 32'hEAFFFFFE);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_imem_we", bus.imem_we, 1'b0);
    reset = 1'b0;

    // Directed ISA vectors, memory always ready
    rdy_mode = 0;
    send(K_ADD, 1'b1, 4'd1, 4'd2, 4'd0, 24'd5, 1'b0, 1'b1, 8'h00);
    send(K_CMP, 1'b0, 4'd3, 4'd3, 4'd4, 24'd0, 1'b0, 1'b0, 8'h00);
    send(K_MOV, 1'b1, 4'd7, 4'd9, 4'd0, 24'h0000FF, 1'b0, 1'b0, 8'h00);
    send(K_LDR, 1'b0, 4'd5, 4'd6, 4'd0, 24'd8, 1'b0, 1'b0, 8'h00);
    send(K_STR, 1'b0, 4'd5, 4'd6, 4'd0, 24'd8, 1'b0, 1'b0, 8'h00);
    send(K_B, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1, 1'b0, 8'h00);
    wait_idle();
    chk("count_after_directed", bus.count, 9'd6);

    // Memory stalls three cycles per write
    rdy_mode = 2;
    send(K_SUB, 1'b0, 4'd2, 4'd3, 4'd4, 24'd0, 1'b0, 1'b0, 8'h00);
    send(K_ORR, 1'b1, 4'd8, 4'd9, 4'd0, 24'h0000A5, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // Address wrap from the top of memory
    rdy_mode = 0;
    send(K_AND, 1'b0, 4'd1, 4'd1, 4'd2, 24'd0, 1'b0, 1'b1, 8'hFF);
    send(K_ADD, 1'b1, 4'd4, 4'd4, 4'd0, 24'd1, 1'b0, 1'b0, 8'h00);
    wait_idle();
    chk("wr_addr_after_wrap", bus.wr_addr, 8'h01);

    // Random traffic with random memory backpressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 24'($urandom()),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
    end
    wait_idle();

    // Illegal kind: no write, sticky error
    rdy_mode = 0;
    chk("err_before_illegal", bus.err, 1'b0);
    send(4'hF, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b0, 1'b0, 8'h00);
    send(K_MOV, 1'b0, 4'd1, 4'd0, 4'd2, 24'd0, 1'b1, 1'b0, 8'h00);
    wait_idle();
    chk("err_sticky", bus.err, 1'b1);

    // Reset in the middle of a stalled write
    rdy_mode = 2;
    send(K_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 24'd0, 1'b0, 1'b0, 8'h00);
    #2;
    chk("pre_reset_we", bus.imem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_reset_we", bus.imem_we, 1'b0);
    chk("async_reset_count", bus.count, 9'd0);
    chk("async_reset_wr_addr", bus.wr_addr, 8'h00);
    chk("async_reset_err", bus.err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    send(K_SUB, 1'b1, 4'd6, 4'd7, 4'd0, 24'd3, 1'b1, 1'b0, 8'h00);
    wait_idle();
    chk("count_after_reset", bus.count, 9'd1);
    chk("wr_addr_after_reset", bus.wr_addr, 8'h01);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
